// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Merges single-cycle ALU results and buffered load results onto
//               the single regfile write port. The ALU has strict priority and
//               all write-port outputs are registered. Defining
//               WB_SCOREBOARD_EN adds a pending-register scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int LD_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    input  logic [4:0]                  alu_rd,
    input  logic [31:0]                 alu_data,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [4:0]                  ld_rd,
    input  logic [31:0]                 ld_data,
`ifdef WB_SCOREBOARD_EN
    input  logic                        issue_valid,
    input  logic [4:0]                  issue_rd,
    output logic [31:0]                 pending,
`endif
    output logic                        we,
    output logic [4:0]                  writeaddr,
    output logic [31:0]                 writedata,
    output logic [$clog2(LD_DEPTH):0]   fifo_count
);

    localparam int c_PTR_W = $clog2(LD_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [36:0]          r_mem [LD_DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic w_ld_acc;
    logic w_alu_wr;
    logic w_fifo_ne;
    logic w_pop;
    logic w_bypass;
    logic w_push;

    assign ld_ready   = (r_count != c_CNT_W'(LD_DEPTH));
    assign fifo_count = r_count;

    // rd==0 results are accepted but never written nor queued.
    assign w_ld_acc  = ld_valid & ld_ready;
    assign w_alu_wr  = alu_valid & (alu_rd != 5'd0);
    assign w_fifo_ne = (r_count != '0);
    assign w_pop     = ~w_alu_wr & w_fifo_ne;
    assign w_bypass  = ~w_alu_wr & ~w_fifo_ne & w_ld_acc & (ld_rd != 5'd0);
    assign w_push    = w_ld_acc & (ld_rd != 5'd0) & ~w_bypass;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {ld_rd, ld_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            we        <= 1'b0;
            writeaddr <= 5'd0;
            writedata <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            we      <= w_alu_wr | w_pop | w_bypass;
            if (w_alu_wr) begin
                writeaddr <= alu_rd;
                writedata <= alu_data;
            end else if (w_pop) begin
                writeaddr <= r_mem[r_rd_ptr][36:32];
                writedata <= r_mem[r_rd_ptr][31:0];
            end else if (w_bypass) begin
                writeaddr <= ld_rd;
                writedata <= ld_data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] w_pending_nxt;

    // Clear follows the registered write; a same-cycle issue re-sets the bit.
    always_comb begin
        w_pending_nxt = pending;
        if (we) begin
            w_pending_nxt[writeaddr] = 1'b0;
        end
        if (issue_valid) begin
            w_pending_nxt[issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 32'd0;
        end else begin
            pending <= w_pending_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Scoreboard bench for regfile_wb_arbiter; WB_SCOREBOARD_EN
//               additionally exercises the pending-register outputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int LD_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        we;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;
    logic [2:0]  fifo_count;
`ifdef WB_SCOREBOARD_EN
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] pending;
`endif

    regfile_wb_arbiter #(.LD_DEPTH(LD_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
`ifdef WB_SCOREBOARD_EN
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .pending    (pending),
`endif
        .we         (we),
        .writeaddr  (writeaddr),
        .writedata  (writedata),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mq[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic exp_we;
    logic exp_ready;
    logic obs_ready;

    // Drives one cycle of stimulus, advances the behavioural model and queues
    // the write expected one clock later.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
        logic acc;
        logic used;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid  = lv; ld_rd  = lr; ld_data  = ldd;
        #1;
        obs_ready = ld_ready;
        exp_ready = (mq.size() != LD_DEPTH);
        acc    = lv && exp_ready;
        used   = 1'b0;
        exp_we = 1'b0;
        if (av && ar != 5'd0) begin
            exp_q.push_back('{ar, ad});
            exp_we = 1'b1;
        end else if (mq.size() != 0) begin
            exp_q.push_back(mq.pop_front());
            exp_we = 1'b1;
        end else if (acc && lr != 5'd0) begin
            exp_q.push_back('{lr, ldd});
            exp_we = 1'b1;
            used   = 1'b1;
        end
        if (acc && lr != 5'd0 && !used) mq.push_back('{lr, ldd});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
`ifdef WB_SCOREBOARD_EN
        issue_valid = 1'b0; issue_rd = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (we !== 1'b0 || writeaddr !== 5'd0 || writedata !== 32'd0 ||
            fifo_count !== 3'd0 || ld_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: we=%b addr=%0d data=%h cnt=%0d rdy=%b, required 0 0 0 0 1",
                     we, writeaddr, writedata, fifo_count, ld_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu;
        logic [4:0]  rds [3] = '{5'd5, 5'd31, 5'd1};
        logic [31:0] ds  [3] = '{32'hDEADBEEF, 32'h0, 32'hFFFF_FFFF};
        wr_t e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, rds[i], ds[i], 1'b0, 5'd0, 32'd0);
            n_vec++;
            if (we !== exp_we) begin
                n_err++;
                $display("FAIL alu_we[%0d]: got %b, required %b", i, we, exp_we);
            end
            if (we === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (writeaddr !== e.rd || writedata !== e.d) begin
                    n_err++;
                    $display("FAIL alu_write[%0d]: got %0d/%h, required %0d/%h",
                             i, writeaddr, writedata, e.rd, e.d);
                end
            end
        end
    endtask

    task automatic test_load_bypass;
        wr_t e;
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
        n_vec++;
        if (we !== 1'b1 || fifo_count !== 3'd0) begin
            n_err++;
            $display("FAIL bypass_we_cnt: got we=%b cnt=%0d, required 1 0", we, fifo_count);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (writeaddr !== e.rd || writedata !== e.d) begin
                n_err++;
                $display("FAIL bypass_write: got %0d/%h, required %0d/%h",
                         writeaddr, writedata, e.rd, e.d);
            end
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_vec++;
        if (we !== 1'b0 || writeaddr !== 5'd7 || writedata !== 32'h1234) begin
            n_err++;
            $display("FAIL idle_hold: got we=%b %0d/%h, required 0 7/00001234",
                     we, writeaddr, writedata);
        end
    endtask

    // Backpressure and in-order drain, including the pop-while-full cycle.
    task automatic test_backpressure;
        wr_t e;
        for (int i = 0; i < 12; i++) begin
            if (i < 6)
                step(1'b1, 5'(i + 1), 32'hA0 + 32'(i), i < 5, 5'(10 + i), 32'h100 + 32'(i));
            else if (i < 8)
                step(1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'h200 + 32'(i));
            else
                step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            n_vec++;
            if (obs_ready !== exp_ready) begin
                n_err++;
                $display("FAIL bp_ready[%0d]: got %b, required %b", i, obs_ready, exp_ready);
            end
            n_vec++;
            if (we !== exp_we || fifo_count !== 3'(mq.size())) begin
                n_err++;
                $display("FAIL bp_we_cnt[%0d]: got %b/%0d, required %b/%0d",
                         i, we, fifo_count, exp_we, mq.size());
            end
            if (we === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (writeaddr !== e.rd || writedata !== e.d) begin
                    n_err++;
                    $display("FAIL bp_write[%0d]: got %0d/%h, required %0d/%h",
                             i, writeaddr, writedata, e.rd, e.d);
                end
            end
        end
    endtask

    task automatic test_rd_zero;
        step(1'b1, 5'd0, 32'h5555, 1'b1, 5'd0, 32'h6666);
        n_vec++;
        if (we !== 1'b0 || fifo_count !== 3'd0 || exp_we !== 1'b0) begin
            n_err++;
            $display("FAIL rd_zero: got we=%b cnt=%0d, required 0 0", we, fifo_count);
        end
    endtask

    task automatic test_same_rd;
        wr_t e;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) step(1'b1, 5'd12, 32'hAAAA, 1'b1, 5'd12, 32'hBBBB);
            else        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            n_vec++;
            if (we !== exp_we) begin
                n_err++;
                $display("FAIL same_rd_we[%0d]: got %b, required %b", i, we, exp_we);
            end
            if (we === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (writeaddr !== e.rd || writedata !== e.d) begin
                    n_err++;
                    $display("FAIL same_rd_write[%0d]: got %0d/%h, required %0d/%h",
                             i, writeaddr, writedata, e.rd, e.d);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'(i + 1), 32'hC0 + 32'(i), 1'b1, 5'(11 + i), 32'hD0 + 32'(i));
        exp_q.delete();
        n_vec++;
        if (fifo_count !== 3'd3) begin
            n_err++;
            $display("FAIL mid_prefill: got cnt=%0d, required 3", fifo_count);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (we !== 1'b0 || fifo_count !== 3'd0 || ld_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: got we=%b cnt=%0d rdy=%b, required 0 0 1",
                     we, fifo_count, ld_ready);
        end
        mq.delete();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_vec++;
        if (we !== 1'b0 || fifo_count !== 3'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: got we=%b cnt=%0d, required 0 0", we, fifo_count);
        end
    endtask

`ifdef WB_SCOREBOARD_EN
    task automatic test_scoreboard;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        issue_valid = 1'b0;
        n_vec++;
        if (pending[9] !== 1'b1 || pending[0] !== 1'b0) begin
            n_err++;
            $display("FAIL sb_set: got pending=%h, required bit9 set", pending);
        end
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        void'(exp_q.pop_front());
        n_vec++;
        if (we !== 1'b1 || pending[9] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_hold: got we=%b pend9=%b, required 1 1", we, pending[9]);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_vec++;
        if (pending[9] !== 1'b0) begin
            n_err++;
            $display("FAIL sb_clear: got pend9=%b, required 0", pending[9]);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_alu;
        test_load_bypass;
        test_backpressure;
        test_rd_zero;
        test_same_rd;
        test_reset_mid;
`ifdef WB_SCOREBOARD_EN
        test_scoreboard;
`endif
        n_vec++;
        if (exp_q.size() != 0 || mq.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d unretired writes, required 0",
                     exp_q.size() + mq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
